// File: rtl/i2s_dac_serializer.sv
// I2S transmitter for the WM8731 DAC. The codec masters BCLK/DACLRCK; a one-pair holding
// buffer feeds each frame, and the previous pair is repeated when a frame starts empty.
module i2s_dac_serializer #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] leftSampleIn,
  input  logic [WIDTH-1:0] rightSampleIn,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  output logic             AUD_DACDAT,
  output logic             frame_start,
  output logic             underrun
);
  // state | meaning
  // IDLE  | after reset, waiting for the first left slot; output held at 0
  // LEFT  | shifting out the left sample
  // RIGHT | shifting out the right sample
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q;
  logic                   bclk_prev_q, lrck_cap_q;
  logic                   bclk_s, lrck_s, bclk_fall, slot_start, left_start, right_start;

  logic [1:0]       state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dacdat_q, dacdat_d;
  logic             fs_q, fs_d, ur_q, ur_d;

  assign bclk_s      = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall   = bclk_prev_q & ~bclk_s;
  // A slot begins when LRCK differs from the value seen at the previous falling BCLK
  assign slot_start  = bclk_fall & (lrck_s != lrck_cap_q);
  assign left_start  = slot_start & ~lrck_s;
  assign right_start = slot_start & lrck_s;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_cap_q  <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_prev_q <= bclk_s;
      if (bclk_fall) lrck_cap_q <= lrck_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    dacdat_d    = dacdat_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;

    if (sample_valid && !hold_full_q) begin
      hold_l_d    = leftSampleIn;
      hold_r_d    = rightSampleIn;
      hold_full_d = 1'b1;
    end

    if (left_start) begin
      state_d = LEFT;
      fs_d    = 1'b1;
      if (hold_full_q) begin
        last_l_d    = hold_l_q;
        last_r_d    = hold_r_q;
        shift_d     = hold_l_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d = last_l_q;
        ur_d    = 1'b1;
      end
    end else if (right_start && state_q != IDLE) begin
      state_d = RIGHT;
      shift_d = last_r_q;
    end

    // I2S one-bit delay: the slot's first BCLK carries a 0, MSB follows on the next one
    if (slot_start) begin
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else if (bclk_fall) begin
      if (state_q != IDLE && bit_cnt_q < CNT_MAX) begin
        dacdat_d  = shift_q[WIDTH-1];
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dacdat_q    <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      dacdat_q    <= dacdat_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign AUD_DACDAT   = dacdat_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: codec BCLK/LRCK model, bit capture at rising BCLK,
// frame-level reference model of the holding buffer and repeat-on-underrun rule.
module tb_i2s_dac_serializer;
  localparam int WIDTH = 16;
  localparam int HALF  = 8;  // CLOCK_50 periods per BCLK half period

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N = 1'b0;
  logic [WIDTH-1:0] leftSampleIn = '0;
  logic [WIDTH-1:0] rightSampleIn = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             AUD_BCLK = 1'b1;
  logic             AUD_DACLRCK = 1'b1;
  logic             AUD_DACDAT;
  logic             frame_start;
  logic             underrun;

  i2s_dac_serializer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .leftSampleIn (leftSampleIn),
    .rightSampleIn(rightSampleIn),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt  = 0;
  int ur_cnt  = 0;
  int n_acc   = 0;

  always @(posedge CLOCK_50) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (underrun)    ur_cnt <= ur_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: one holding slot plus the pair currently being framed
  logic [WIDTH-1:0] m_hold_l, m_hold_r, m_last_l, m_last_r;
  bit               m_full;

  task automatic model_reset();
    m_full   = 1'b0;
    m_hold_l = '0;
    m_hold_r = '0;
    m_last_l = '0;
    m_last_r = '0;
  endtask

  task automatic model_left_start(output bit ur);
    ur = !m_full;
    if (m_full) begin
      m_last_l = m_hold_l;
      m_last_r = m_hold_r;
      m_full   = 1'b0;
    end
  endtask

  // Upstream source, stepped on every falling CLOCK_50 edge. valid only changes here and
  // ready only changes on rising edges, so valid & (ready at last negedge) means a transfer.
  bit rdy_prev = 1'b1;
  bit src_cont = 1'b0;

  task automatic src_step();
    if (sample_valid && rdy_prev) begin
      check("accept_while_full", 64'(m_full), 64'(0));
      m_hold_l = leftSampleIn;
      m_hold_r = rightSampleIn;
      m_full   = 1'b1;
      n_acc++;
      if (src_cont) begin
        leftSampleIn  = WIDTH'($urandom);
        rightSampleIn = WIDTH'($urandom);
      end else begin
        sample_valid = 1'b0;
      end
    end
    rdy_prev = sample_ready;
  endtask

  task automatic run_slot(input bit lr, input int n, input logic [WIDTH-1:0] s, input int rst_k,
                          input int offer_mode, input int offer_k,
                          input logic [WIDTH-1:0] ol, input logic [WIDTH-1:0] orr,
                          input bit edge_offer, input bit chk_ready_edge, input string tag);
    logic [63:0] got, exp;
    got = '0;
    exp = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK_50); src_step();
      AUD_BCLK = 1'b0;
      if (k == 0) AUD_DACLRCK = lr;
      for (int c = 1; c < HALF; c++) begin
        @(negedge CLOCK_50); src_step();
        if (k == 0 && chk_ready_edge) begin
          if (c == 2) check({tag, "_rdy_pre"},  64'(sample_ready), 64'(0));
          if (c == 3) check({tag, "_rdy_rise"}, 64'(sample_ready), 64'(1));
          if (c == 4) check({tag, "_rdy_drop"}, 64'(sample_ready), 64'(0));
        end
        if (k == 0 && edge_offer && c == 2) begin
          leftSampleIn = ol; rightSampleIn = orr; src_cont = 1'b0; sample_valid = 1'b1;
        end
        if (offer_mode != 0 && k == offer_k && c == 2) begin
          leftSampleIn = ol; rightSampleIn = orr; src_cont = (offer_mode == 2); sample_valid = 1'b1;
        end
        if (k == rst_k && c == 1) begin
          RESET_N = 1'b0;
          #1;
          check({tag, "_rst_dacdat"}, 64'(AUD_DACDAT), 64'(0));
          model_reset();
        end
        if (k == rst_k && c == 3) RESET_N = 1'b1;
        if (k == n / 2 && c == HALF - 1) check({tag, "_ready"}, 64'(sample_ready), 64'(!m_full));
      end
      @(negedge CLOCK_50); src_step();
      got[k] = AUD_DACDAT;
      if (!(rst_k >= 0 && k >= rst_k) && k >= 1 && k <= WIDTH) exp[k] = s[WIDTH-k];
      AUD_BCLK = 1'b1;
      for (int c = 1; c < HALF; c++) begin
        @(negedge CLOCK_50); src_step();
      end
    end
    check({tag, "_data"}, got, exp);
  endtask

  task automatic run_frame(input int nl, input int nr, input logic [WIDTH-1:0] el,
                           input logic [WIDTH-1:0] er, input bit eur, input int offer_mode,
                           input int offer_k, input logic [WIDTH-1:0] ol, input logic [WIDTH-1:0] orr,
                           input bit edge_offer, input bit chk_ready_edge, input int rst_k,
                           input int exp_acc, input string tag);
    int fs0, ur0, acc0;
    fs0  = fs_cnt;
    ur0  = ur_cnt;
    acc0 = n_acc;
    run_slot(1'b0, nl, el, rst_k, 0, -1, ol, orr, edge_offer, chk_ready_edge, {tag, "L"});
    run_slot(1'b1, nr, er, -1, offer_mode, offer_k, ol, orr, 1'b0, 1'b0, {tag, "R"});
    check({tag, "_frame_start"}, 64'(fs_cnt - fs0), 64'(1));
    check({tag, "_underrun"}, 64'(ur_cnt - ur0), 64'(eur));
    if (exp_acc >= 0) check({tag, "_accepts"}, 64'(n_acc - acc0), 64'(exp_acc));
  endtask

  typedef struct {
    int               nl, nr;
    logic [WIDTH-1:0] el, er;
    bit               eur;
    int               offer_mode, offer_k;
    logic [WIDTH-1:0] ol, orr;
    bit               edge_offer;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit               mur;
    int               nl, nr, om, ok;
    logic [WIDTH-1:0] pl, pr;

    tbl[0] = '{32, 32, 16'h8001, 16'h7FFE, 1'b0, 1, 8, 16'h1234, 16'hABCD, 1'b0};
    tbl[1] = '{32, 32, 16'h1234, 16'hABCD, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{32, 32, 16'h1234, 16'hABCD, 1'b1, 0, 0, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{32, 32, 16'h1234, 16'hABCD, 1'b1, 0, 0, 16'h0F0F, 16'hF00F, 1'b1};
    tbl[4] = '{12, 20, 16'h0F0F, 16'hF00F, 1'b0, 1, 3, 16'h5A5A, 16'hC3C3, 1'b0};
    tbl[5] = '{16, 17, 16'h5A5A, 16'hC3C3, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{17, 16, 16'h5A5A, 16'hC3C3, 1'b1, 0, 0, 16'h0000, 16'h0000, 1'b0};

    model_reset();
    repeat (4) @(negedge CLOCK_50);
    check("reset_dacdat",      64'(AUD_DACDAT),   64'(0));
    check("reset_ready",       64'(sample_ready), 64'(1));
    check("reset_frame_start", 64'(frame_start),  64'(0));
    check("reset_underrun",    64'(underrun),     64'(0));
    RESET_N = 1'b1;

    // Right slot before any left slot: output stays 0 while the first pair is queued
    run_slot(1'b1, 32, '0, -1, 1, 4, 16'h8001, 16'h7FFE, 1'b0, 1'b0, "pre");

    for (int i = 0; i < 7; i++) begin
      model_left_start(mur);
      run_frame(tbl[i].nl, tbl[i].nr, tbl[i].el, tbl[i].er, tbl[i].eur, tbl[i].offer_mode,
                tbl[i].offer_k, tbl[i].ol, tbl[i].orr, tbl[i].edge_offer, 1'b0, -1, -1,
                $sformatf("tbl%0d", i));
    end

    // Continuous valid: one pair consumed per frame, ready re-opens right after left start
    model_left_start(mur);
    run_frame(32, 32, m_last_l, m_last_r, mur, 2, 4, 16'h1111, 16'h2222, 1'b0, 1'b0, -1, 1, "cont0");
    for (int i = 1; i <= 3; i++) begin
      model_left_start(mur);
      run_frame(32, 32, m_last_l, m_last_r, mur, 0, 0, '0, '0, 1'b0, 1'b1, -1, 1,
                $sformatf("cont%0d", i));
    end
    src_cont     = 1'b0;
    sample_valid = 1'b0;

    // Reset mid left slot; pair queued after release goes out in the next frame
    model_left_start(mur);
    run_frame(32, 32, m_last_l, '0, mur, 1, 5, 16'hC0DE, 16'h0BEE, 1'b0, 1'b0, 10, -1, "rst");
    model_left_start(mur);
    check("rst_next_underrun_model", 64'(mur), 64'(0));
    run_frame(32, 32, m_last_l, m_last_r, mur, 0, 0, '0, '0, 1'b0, 1'b0, -1, -1, "rst_next");

    for (int i = 0; i < 8; i++) begin
      nl = int'($urandom_range(34, 12));
      nr = int'($urandom_range(34, 12));
      om = int'($urandom_range(1, 0));
      ok = int'($urandom_range(nr - 1, 1));
      pl = WIDTH'($urandom);
      pr = WIDTH'($urandom);
      model_left_start(mur);
      run_frame(nl, nr, m_last_l, m_last_r, mur, om, ok, pl, pr, 1'b0, 1'b0, -1, -1,
                $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
